// File: rtl/storage_pkg.sv
// rtl/storage_pkg.sv - shared QSPI read-engine types and constants
package storage_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_GAP
    } qspi_state_e;

    localparam logic [7:0] QSPI_CMD_QUAD_READ = 8'h6B;
    localparam int         QSPI_CMD_BITS      = 8;
    localparam int         QSPI_ADDR_BITS     = 24;
    localparam int         QSPI_DUMMY_CYCLES  = 8;
    localparam int         QSPI_DATA_NIBBLES  = 8;

    // WP#/HOLD# driven high, IO1 is the only input while the bus is idle
    localparam logic [3:0] QSPI_IO_O_IDLE = 4'b1100;
    localparam logic [3:0] QSPI_IO_T_IDLE = 4'b0010;
    localparam logic [3:0] QSPI_IO_T_READ = 4'b1111;

endpackage

// File: rtl/qspi_flash_reader_sck_gen.sv
// rtl/qspi_flash_reader_sck_gen.sv - divided SPI clock with edge strobes
module qspi_sck_gen #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic sck,
    output logic rise_tick,
    output logic fall_tick
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] div_cnt;
    logic          wrap;

    // Strobes fire in the cycle before sck toggles, so the consumer acts on the toggling edge
    assign wrap      = enable && !clear && (div_cnt == CW'(CLK_DIV - 1));
    assign rise_tick = wrap && !sck;
    assign fall_tick = wrap && sck;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (enable) begin
            if (wrap) begin
                div_cnt <= '0;
                sck     <= !sck;
            end else begin
                div_cnt <= div_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/qspi_flash_reader.sv
// rtl/qspi_flash_reader.sv - single-word QSPI quad output fast read engine
module qspi_flash_reader
    import storage_pkg::*;
#(
    parameter int ADDR_W  = 22,
    parameter int CLK_DIV = 1,
    parameter int CS_GAP  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              busy,
    output logic              qspi_ck_o,
    output logic              qspi_cs_o,
    output logic [3:0]        qspi_io_o,
    output logic [3:0]        qspi_io_t,
    input  logic [3:0]        qspi_io_i
);
    localparam int SHIFT_W = QSPI_CMD_BITS + QSPI_ADDR_BITS;
    localparam int GW      = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [5:0] LAST_CMD   = 6'(QSPI_CMD_BITS - 1);
    localparam logic [5:0] LAST_ADDR  = 6'(SHIFT_W - 1);
    localparam logic [5:0] LAST_DUMMY = 6'(SHIFT_W + QSPI_DUMMY_CYCLES - 1);
    localparam logic [5:0] LAST_DATA  = 6'(SHIFT_W + QSPI_DUMMY_CYCLES + QSPI_DATA_NIBBLES - 1);

    qspi_state_e        state, state_next;
    logic [5:0]         sck_cnt;
    logic [SHIFT_W-1:0] shift;
    logic [31:0]        data_buf;
    logic [GW-1:0]      gap_cnt;
    logic               sck_en, rise_tick, fall_tick, done, accept;

    assign accept = req_valid && req_ready;
    assign sck_en = (state == ST_CMD) || (state == ST_ADDR) || (state == ST_DUMMY) || (state == ST_DATA);
    assign done   = (state == ST_DATA) && fall_tick && (sck_cnt == LAST_DATA);

    qspi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk       (clk),
        .rst       (rst),
        .enable    (sck_en),
        .clear     (!sck_en),
        .sck       (qspi_ck_o),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (req_valid) state_next = ST_CMD;
            ST_CMD:   if (fall_tick && sck_cnt == LAST_CMD) state_next = ST_ADDR;
            ST_ADDR:  if (fall_tick && sck_cnt == LAST_ADDR) state_next = ST_DUMMY;
            ST_DUMMY: if (fall_tick && sck_cnt == LAST_DUMMY) state_next = ST_DATA;
            ST_DATA:  if (done) state_next = ST_GAP;
            ST_GAP:   if (gap_cnt == GW'(CS_GAP - 1)) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b1;
        qspi_cs_o = 1'b0;
        qspi_io_o = QSPI_IO_O_IDLE;
        qspi_io_t = QSPI_IO_T_IDLE;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                qspi_cs_o = 1'b1;
            end
            ST_CMD, ST_ADDR:   qspi_io_o = {3'b110, shift[SHIFT_W-1]};
            ST_DUMMY, ST_DATA: qspi_io_t = QSPI_IO_T_READ;
            ST_GAP:            qspi_cs_o = 1'b1;
            default: ;
        endcase
    end

    // sck_cnt counts completed SCK periods; in DATA its low bits are the nibble index
    always_ff @(posedge clk) begin
        if (rst) begin
            shift     <= '0;
            sck_cnt   <= '0;
            data_buf  <= '0;
            gap_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= done;
            if (state == ST_IDLE) begin
                sck_cnt <= '0;
                gap_cnt <= '0;
                if (accept) shift <= {QSPI_CMD_QUAD_READ, QSPI_ADDR_BITS'({req_addr, 2'b00})};
            end
            if (state == ST_GAP) gap_cnt <= gap_cnt + GW'(1);
            if (fall_tick) begin
                sck_cnt <= sck_cnt + 6'd1;
                shift   <= shift << 1;
            end
            // High nibble first within a byte, first byte into bits [7:0]
            if (rise_tick && state == ST_DATA)
                data_buf[{sck_cnt[2:1], ~sck_cnt[0], 2'b00} +: 4] <= qspi_io_i;
            if (done) rsp_data <= data_buf;
        end
    end

endmodule

// File: tb/tb_qspi_flash_reader.sv
// tb/tb_qspi_flash_reader.sv - self-checking bench for qspi_flash_reader
`timescale 1ns/1ps
module tb_qspi_flash_reader;
    localparam int N = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [N-1:0]       req_valid = '0;
    logic [N-1:0][21:0] req_addr = '0;
    logic [N-1:0]       req_ready, rsp_valid, busy, ck, cs;
    logic [N-1:0][31:0] rsp_data;
    logic [N-1:0][3:0]  io_o, io_t;
    int                 n_checks = 0;
    int                 n_fail = 0;
    bit                 chk_en = 1'b0;
    logic [31:0]        mem [128];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [21:0] a);
        return mem[a[6:0]];
    endfunction

    function automatic logic [7:0] flash_byte(input logic [23:0] ba);
        logic [31:0] w;
        w = mem[ba[8:2]];
        return w[8*ba[1:0] +: 8];
    endfunction

    for (genvar g = 0; g < N; g++) begin : inst
        localparam int D = (g == 0) ? 1 : 3;
        localparam int G = (g == 0) ? 2 : 4;
        localparam int T = 96 * D;

        logic [3:0]  fl_io = 4'h0;
        int          fl_rises = 0;
        logic [31:0] fl_sh = '0;
        bit          pend = 1'b0;
        int          k = 0;
        logic [21:0] m_addr = '0;
        logic [31:0] m_data = '0;

        qspi_flash_reader #(.ADDR_W(22), .CLK_DIV(D), .CS_GAP(G)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_addr  (req_addr[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_data  (rsp_data[g]),
            .busy      (busy[g]),
            .qspi_ck_o (ck[g]),
            .qspi_cs_o (cs[g]),
            .qspi_io_o (io_o[g]),
            .qspi_io_t (io_t[g]),
            .qspi_io_i (fl_io)
        );

        // Flash: shift in command+address on rising SCK, return bytes on falling SCK
        always @(negedge cs[g]) begin
            fl_rises = 0;
            fl_sh = '0;
        end

        always @(posedge ck[g]) begin
            if (!cs[g]) begin
                if (fl_rises < 32) fl_sh = {fl_sh[30:0], io_o[g][0]};
                fl_rises++;
                if (fl_rises == 32)
                    check($sformatf("cmd_addr%0d", g), fl_sh, {8'h6B, m_addr, 2'b00});
            end
        end

        always @(negedge ck[g]) begin
            if (fl_rises >= 40 && fl_rises < 48) begin
                int         j;
                logic [7:0] b;
                j = fl_rises - 40;
                b = flash_byte(fl_sh[23:0] + 24'(j / 2));
                fl_io = (j % 2 == 0) ? b[7:4] : b[3:0];
            end
        end

        // Transaction model: k counts clk edges since the accept edge
        always @(posedge clk) begin
            bit rdy;
            rdy = !pend || k >= T + G;
            if (rst) begin
                pend = 1'b0;
                m_data = '0;
            end else begin
                if (pend) k++;
                if (pend && k == T) m_data = mem_word(m_addr);
                if (req_valid[g] && rdy) begin
                    pend = 1'b1;
                    k = 0;
                    m_addr = req_addr[g];
                end
            end
        end

        always @(negedge clk) begin
            if (chk_en) begin
                logic        exp_rdy, exp_cs, exp_ck, exp_rv;
                logic [31:0] stream;
                exp_rdy = !pend || k >= T + G;
                exp_cs  = !(pend && k < T);
                exp_ck  = pend && k < T && ((k / D) % 2 == 1);
                exp_rv  = pend && k == T;
                check($sformatf("ctl%0d", g), {req_ready[g], busy[g], cs[g], ck[g], rsp_valid[g]},
                      {exp_rdy, !exp_rdy, exp_cs, exp_ck, exp_rv});
                check($sformatf("rsp_data%0d", g), rsp_data[g], m_data);
                stream = {8'h6B, m_addr, 2'b00};
                if (!exp_cs && k < 64 * D)
                    check($sformatf("io_cmd_addr%0d", g), {io_t[g], io_o[g]},
                          {4'b0010, 3'b110, stream[31 - k / (2 * D)]});
                else if (!exp_cs)
                    check($sformatf("io_t_read%0d", g), io_t[g], 4'b1111);
                else if (exp_rdy)
                    check($sformatf("io_idle%0d", g), {io_t[g], io_o[g]}, 8'b0010_1100);
            end
        end
    end

    task automatic wait_ready(input int g);
        int n;
        n = 0;
        while (!req_ready[g] && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ready_wait", {31'b0, req_ready[g]}, 32'd1);
    endtask

    task automatic do_read(input int g, input logic [21:0] a, output int lat);
        wait_ready(g);
        req_valid[g] = 1'b1;
        req_addr[g] = a;
        @(posedge clk);
        #1;
        req_valid[g] = 1'b0;
        lat = 0;
        while (!rsp_valid[g] && lat < 2000) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n, lowc, pulses;
        for (int i = 0; i < 128; i++) mem[i] = 32'h9E3779B9 * i + 32'h01234567;
        mem[0]     = 32'h00000297;
        mem['h10]  = 32'h00000513;

        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < N; g++) begin
            check("reset_ctl", {req_ready[g], busy[g], rsp_valid[g], ck[g], cs[g]}, 5'b10001);
            check("reset_io", {io_o[g], io_t[g]}, 8'b1100_0010);
            check("reset_data", rsp_data[g], 32'h0);
        end
        rst = 1'b0;
        chk_en = 1'b1;

        do_read(0, 22'h0, lat);
        check("lat_div1", lat, 96);
        check("word0", rsp_data[0], 32'h00000297);

        do_read(0, 22'h10, lat);
        check("lat_div1_b", lat, 96);
        check("word10", rsp_data[0], 32'h00000513);
        check("addr_bytes", inst[0].fl_sh, 32'h6B000040);

        // Back-to-back with a held request on the divided instance
        wait_ready(1);
        req_valid[1] = 1'b1;
        req_addr[1] = 22'h21;
        @(posedge clk);
        #1;
        lat = 0;
        while (!rsp_valid[1] && lat < 2000) begin @(posedge clk); #1; lat++; end
        check("lat_div3", lat, 288);
        n = 0;
        while (cs[1] && n < 100) begin @(posedge clk); #1; n++; end
        check("b2b_accept_gap", n, 5);
        req_valid[1] = 1'b0;
        lat = 0;
        while (!rsp_valid[1] && lat < 2000) begin @(posedge clk); #1; lat++; end
        check("lat_div3_b", lat, 288);

        // Abort during DATA nibble 4
        wait_ready(0);
        req_valid[0] = 1'b1;
        req_addr[0] = 22'h10;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        repeat (88) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ctl", {cs[0], ck[0], req_ready[0], busy[0]}, 4'b1010);
        check("abort_data", rsp_data[0], 32'h0);
        rst = 1'b0;
        pulses = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (rsp_valid[0]) pulses++;
        end
        check("abort_no_rsp", pulses, 0);

        for (int a = 0; a < 'h50; a++) begin
            do_read(0, 22'(a), lat);
            check("sweep", rsp_data[0], mem_word(22'(a)));
        end

        do_read(0, 22'h3FFFFF, lat);
        check("wrap_addr", {8'h0, inst[0].fl_sh[23:0]}, 32'h00FFFFFC);
        check("wrap_data", rsp_data[0], mem[127]);

        // Request toggling while busy must not start another transaction
        wait_ready(1);
        req_valid[1] = 1'b1;
        req_addr[1] = 22'h7;
        @(posedge clk);
        #1;
        lowc = cs[1] ? 0 : 1;
        pulses = 0;
        for (int j = 1; j <= 292; j++) begin
            req_valid[1] = (j < 288) ? j[0] : 1'b0;
            @(posedge clk);
            #1;
            if (!cs[1]) lowc++;
            if (rsp_valid[1]) pulses++;
        end
        check("cs_low_cycles", lowc, 288);
        check("toggle_rsp", pulses, 1);

        repeat (10) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
